// File: rtl/vram_bus_arbiter.sv
// vram_bus_arbiter: four-requester single-port VRAM arbiter with fixed two-cycle ack latency.
// Define VRAM_ARB_CPU_PRIORITY_EN to give requester 0 absolute priority over the round-robin group.
module vram_bus_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*ADDR_W-1:0] i_req_addr,
  input  logic [3:0]          i_req_strobe,
  input  logic                i_cpu_write,
  input  logic [31:0]         i_cpu_wrdata,
  input  logic [3:0]          i_cpu_wrbytesel,
  output logic [3:0]          o_req_ack,
  output logic [31:0]         o_rddata,
  output logic                o_vram_en,
  output logic                o_vram_we,
  output logic [ADDR_W-1:0]   o_vram_addr,
  output logic [31:0]         o_vram_wrdata,
  output logic [3:0]          o_vram_wrbytesel,
  input  logic [31:0]         i_vram_rddata,
  output logic [1:0]          o_grant_idx
);
  logic [3:0]        r_pend, r_ack;
  logic              r_en, r_we;
  logic [1:0]        r_idx, r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wrdata;
  logic [3:0]        r_bytesel;
  logic [3:0]        w_elig, w_mask;
  logic [1:0]        w_sel;
  logic              w_grant, w_adv, w_cpu;
  assign w_elig  = i_req_strobe & ~r_pend;
  assign w_grant = |w_elig;
  assign w_cpu   = w_sel == 2'd0;
  // Scan farthest-to-nearest from last_grant+1 so the nearest eligible requester wins.
  always_comb begin
    w_mask = w_elig;
`ifdef VRAM_ARB_CPU_PRIORITY_EN
    w_mask[0] = 1'b0;
`endif
    w_sel = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (w_mask[r_last + 2'(k) + 2'd1]) w_sel = r_last + 2'(k) + 2'd1;
`ifdef VRAM_ARB_CPU_PRIORITY_EN
    if (w_elig[0]) w_sel = 2'd0;
    w_adv = w_grant & ~w_elig[0];
`else
    w_adv = w_grant;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= '0;
      r_ack     <= '0;
      r_en      <= 1'b0;
      r_we      <= 1'b0;
      r_idx     <= '0;
      r_last    <= 2'd3;
      r_addr    <= '0;
      r_wrdata  <= '0;
      r_bytesel <= '0;
    end else begin
      r_en   <= w_grant;
      r_ack  <= r_en ? 4'b0001 << r_idx : 4'b0000;
      r_pend <= (r_pend & ~r_ack) | (w_grant ? 4'b0001 << w_sel : 4'b0000);
      if (w_grant) begin
        r_idx     <= w_sel;
        r_addr    <= i_req_addr[w_sel*ADDR_W +: ADDR_W];
        r_we      <= w_cpu & i_cpu_write;
        r_wrdata  <= w_cpu ? i_cpu_wrdata : 32'd0;
        r_bytesel <= w_cpu ? i_cpu_wrbytesel : 4'd0;
      end
      if (w_adv) r_last <= w_sel;
    end
  end
  assign o_req_ack        = r_ack;
  assign o_rddata         = |r_ack ? i_vram_rddata : 32'd0;
  assign o_vram_en        = r_en;
  assign o_vram_we        = r_we;
  assign o_vram_addr      = r_addr;
  assign o_vram_wrdata    = r_wrdata;
  assign o_vram_wrbytesel = r_bytesel;
  assign o_grant_idx      = r_idx;
endmodule

// File: tb/tb_vram_bus_arbiter.sv
// tb_vram_bus_arbiter: directed and random checks of vram_bus_arbiter against a cycle-count model.
module tb_vram_bus_arbiter;
  localparam int AW = 16;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic [4*AW-1:0] req_addr = '0;
  logic [3:0]    req_strobe = '0;
  logic          cpu_write = 1'b0;
  logic [31:0]   cpu_wrdata = '0;
  logic [3:0]    cpu_wrbytesel = '0;
  logic [3:0]    req_ack;
  logic [31:0]   rddata;
  logic          vram_en, vram_we;
  logic [AW-1:0] vram_addr;
  logic [31:0]   vram_wrdata;
  logic [3:0]    vram_wrbytesel;
  logic [31:0]   vram_rddata = '0;
  logic [1:0]    grant_idx;

  vram_bus_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .i_req_addr(req_addr), .i_req_strobe(req_strobe),
    .i_cpu_write(cpu_write), .i_cpu_wrdata(cpu_wrdata), .i_cpu_wrbytesel(cpu_wrbytesel),
    .o_req_ack(req_ack), .o_rddata(rddata), .o_vram_en(vram_en), .o_vram_we(vram_we),
    .o_vram_addr(vram_addr), .o_vram_wrdata(vram_wrdata), .o_vram_wrbytesel(vram_wrbytesel),
    .i_vram_rddata(vram_rddata), .o_grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  int m_free [4];
  int m_last;
  logic m_en, m_we;
  logic [1:0] m_idx;
  logic [AW-1:0] m_addr;
  logic [31:0] m_wd, m_rd;
  logic [3:0] m_bs, m_ack, m_out;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_we = 0; m_idx = 0; m_addr = 0; m_wd = 0; m_bs = 0; m_ack = 0; m_out = 0;
    m_last = 3;
    for (int i = 0; i < 4; i++) m_free[i] = 0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_en"}, 64'(vram_en), 64'(m_en));
    chk({tag, "_we"}, 64'(vram_we), 64'(m_we));
    chk({tag, "_idx"}, 64'(grant_idx), 64'(m_idx));
    chk({tag, "_addr"}, 64'(vram_addr), 64'(m_addr));
    chk({tag, "_wd"}, 64'(vram_wrdata), 64'(m_wd));
    chk({tag, "_bs"}, 64'(vram_wrbytesel), 64'(m_bs));
    chk({tag, "_ack"}, 64'(req_ack), 64'(m_ack));
    if (m_ack != 0) chk({tag, "_rd"}, 64'(rddata), 64'(m_rd));
  endtask

  // Model: a requester granted in cycle N is busy until N+3; its access is visible in N+1 and acked in N+2.
  task automatic tick(input string tag, input logic [31:0] rd);
    logic [3:0] el, rr, nack;
    int w, c;
    bit any, adv;
    for (int i = 0; i < 4; i++) el[i] = req_strobe[i] && (cyc >= m_free[i]);
    rr = el;
    any = 0; adv = 0; w = 0;
`ifdef VRAM_ARB_CPU_PRIORITY_EN
    rr[0] = 1'b0;
    if (el[0]) begin any = 1; w = 0; end
`endif
    for (int k = 1; k <= 4; k++) begin
      c = (m_last + k) % 4;
      if (!any && rr[c]) begin any = 1; adv = 1; w = c; end
    end
    nack = m_en ? (4'b0001 << m_idx) : 4'b0000;
    m_out = m_out & ~nack;
    if (any) begin
      m_idx  = 2'(w);
      m_addr = req_addr[w*AW +: AW];
      m_we   = (w == 0) && cpu_write;
      m_wd   = (w == 0) ? cpu_wrdata : 32'd0;
      m_bs   = (w == 0) ? cpu_wrbytesel : 4'd0;
      m_free[w] = cyc + 3;
      m_out[w] = 1'b1;
      if (adv) m_last = w;
    end
    m_en = any;
    m_ack = nack;
    m_rd = rd;
    @(posedge clk);
    cyc++;
    #1 vram_rddata = rd;
    #1 check_outs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_strobe = 4'b0000;
    model_reset();
    #1;
    check_outs("rst");
    chk("rst_rddata", 64'(rddata), 64'd0);
    @(posedge clk);
    cyc++;
    #1 rst_n = 1'b1;
    #1;
  endtask

  int exp_seq [9];

  initial begin
    do_reset();

    // Single sprite read
    req_addr[3*AW +: AW] = 16'h1234;
    req_strobe = 4'b1000;
    tick("ex1_g", $urandom);
    chk("ex1_en", 64'(vram_en), 64'd1);
    chk("ex1_addr", 64'(vram_addr), 64'h1234);
    chk("ex1_idx", 64'(grant_idx), 64'd3);
    tick("ex1_a", 32'hDEADBEEF);
    chk("ex1_ack", 64'(req_ack), 64'b1000);
    chk("ex1_rd", 64'(rddata), 64'hDEADBEEF);
    req_strobe = 4'b0000;
    tick("ex1_p", $urandom);
    chk("ex1_single", 64'(req_ack), 64'd0);

    // All four requesters held
    do_reset();
`ifdef VRAM_ARB_CPU_PRIORITY_EN
    exp_seq = '{0, 1, 2, 0, 3, 1, 0, 2, 3};
`else
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 4; i++) req_addr[i*AW +: AW] = AW'(16'h100 * (i + 1));
    req_strobe = 4'b1111;
    for (int n = 0; n < 9; n++) begin
      tick("rr", $urandom);
      chk("rr_en", 64'(vram_en), 64'd1);
      chk("rr_seq", 64'(grant_idx), 64'(exp_seq[n]));
    end
    req_strobe = 4'b0000;
    tick("rr_d0", $urandom);
    tick("rr_d1", $urandom);
    tick("rr_d2", $urandom);

    // CPU write
    req_addr[0 +: AW] = 16'h0010;
    cpu_write = 1'b1; cpu_wrdata = 32'hA5A5A5A5; cpu_wrbytesel = 4'b0101;
    req_strobe = 4'b0001;
    tick("wr_g", $urandom);
    chk("wr_en", 64'(vram_en), 64'd1);
    chk("wr_we", 64'(vram_we), 64'd1);
    chk("wr_addr", 64'(vram_addr), 64'h0010);
    chk("wr_wd", 64'(vram_wrdata), 64'hA5A5A5A5);
    chk("wr_bs", 64'(vram_wrbytesel), 64'b0101);
    tick("wr_a", $urandom);
    chk("wr_ack", 64'(req_ack), 64'b0001);
    req_strobe = 4'b0000; cpu_write = 1'b0;
    tick("wr_p", $urandom);

    // Reset right after a layer1 grant
    req_addr[2*AW +: AW] = 16'h0BEE;
    req_strobe = 4'b0100;
    tick("rm_g", $urandom);
    chk("rm_idx", 64'(grant_idx), 64'd2);
    do_reset();
    for (int n = 0; n < 3; n++) begin
      tick("rm_q", $urandom);
      chk("rm_noack", 64'(req_ack[2]), 64'd0);
    end
    req_strobe = 4'b0110;
    tick("rm_first", $urandom);
    chk("rm_first_idx", 64'(grant_idx), 64'd1);
    req_strobe = 4'b0000;
    tick("rm_d0", $urandom);
    tick("rm_d1", $urandom);
    tick("rm_d2", $urandom);

    // Random traffic with withdrawals before and after grant
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      for (int i = 0; i < 4; i++) begin
        if (m_ack[i]) req_strobe[i] = 1'b0;
        else if (!req_strobe[i] && !m_out[i]) begin
          if ($urandom_range(1) == 1) begin
            req_strobe[i] = 1'b1;
            req_addr[i*AW +: AW] = AW'($urandom);
          end
        end else if (req_strobe[i] && !m_out[i] && $urandom_range(15) == 0) req_strobe[i] = 1'b0;
        else if (req_strobe[i] && m_out[i] && $urandom_range(7) == 0) req_strobe[i] = 1'b0;
      end
      cpu_write = 1'($urandom);
      cpu_wrdata = $urandom;
      cpu_wrbytesel = 4'($urandom);
      tick("rnd", $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
